alimentador_sumador: RTL

// - Upstream operand feeder for the registered 4-bit adder stage.
// - Buffers operand pairs (a,b) in a DEPTH-entry FIFO.
// - Issues one pair per cycle on out_a/out_b with a one-cycle out_enb pulse.
// - out_enb/out_a/out_b connect directly to the adder's enb/a/b; the adder captures them on the following edge.

---
 rtl/alimentador_sumador.sv | 111 +++++++++++
 1 files changed

// File: rtl/alimentador_sumador.sv
// rtl/alimentador_sumador.sv - operand-pair FIFO feeding the registered adder stage.
// Optional sticky push-when-full error register: ALIMENTADOR_ERR_EN.
module alimentador_sumador #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       in_push,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic                       detener,
  output logic                       out_enb,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {VACIO, EMITIENDO, DETENIDO} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [2*WIDTH-1:0]   r_mem [DEPTH];
  logic                 r_enb;
  logic [WIDTH-1:0]     r_a, r_b;
  logic                 w_pop, w_push;
  logic [2*WIDTH-1:0]   w_rd_data;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign out_enb   = r_enb;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign w_rd_data = r_mem[r_rd_ptr];

  // A pop frees a slot on the same edge, so a push at full is accepted when popping.
  assign w_pop  = !detener && (r_state != VACIO) && !empty;
  assign w_push = in_push && (!full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      VACIO: begin
        if (w_push) w_state_nxt = detener ? DETENIDO : EMITIENDO;
      end
      EMITIENDO: begin
        if (detener)                w_state_nxt = DETENIDO;
        else if (w_count_nxt == '0) w_state_nxt = VACIO;
      end
      DETENIDO: begin
        if (!detener) w_state_nxt = (w_count_nxt == '0) ? VACIO : EMITIENDO;
      end
      default: w_state_nxt = VACIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= VACIO;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_enb    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_enb   <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_a      <= w_rd_data[2*WIDTH-1:WIDTH];
        r_b      <= w_rd_data[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b};
  end

`ifdef ALIMENTADOR_ERR_EN
  logic r_error;
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                      r_error <= 1'b0;
    else if (in_push && full && !w_pop) r_error <= 1'b1;
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule
